// File: rtl/tcp_client_fsm.sv
// Client-side TCP three-way handshake engine with SYN/FIN retransmission and bounded retries.
// Optional active close (FIN_WAIT path) is enabled by defining TCP_CLIENT_FSM_FIN_EN.
module tcp_client_fsm #(
    parameter int SEQ_W     = 32,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             open_req,
    input  logic             close_req,
    input  logic [SEQ_W-1:0] isn,
    input  logic             rcv_syn_ack,
    input  logic             rcv_fin_ack,
    input  logic [SEQ_W-1:0] rcv_seq,
    input  logic [SEQ_W-1:0] rcv_ack,
    output logic             send_syn,
    output logic             send_ack,
    output logic             send_fin,
    output logic [SEQ_W-1:0] tx_seq,
    output logic [SEQ_W-1:0] tx_ack,
    output logic             established,
    output logic             fail,
    output logic [2:0]       state
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        CLOSED      = 3'd0,
        SYN_SENT    = 3'd1,
        ESTABLISHED = 3'd2,
        FIN_WAIT    = 3'd3,
        FAILED      = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [SEQ_W-1:0] isn_q, isn_d, peer_q, peer_d;
    logic [SEQ_W-1:0] tx_seq_d, tx_ack_d, isn_p1;
    logic [TW-1:0]    timer_q, timer_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             syn_d, ack_d, fin_d, expired;

`ifdef TCP_CLIENT_FSM_FIN_EN
    logic [SEQ_W-1:0] isn_p2;
    assign isn_p2 = isn_q + SEQ_W'(2);
`else
    logic unused_fin;
    assign unused_fin = rcv_fin_ack;
`endif

    assign isn_p1  = isn_q + SEQ_W'(1);
    // Timer is cleared on the strobe edge, so it reads TIMEOUT-1 on the edge that retransmits.
    assign expired = (timer_q == TW'(TIMEOUT - 1));
    assign state   = state_q;

    always_comb begin
        state_d  = state_q;
        isn_d    = isn_q;
        peer_d   = peer_q;
        timer_d  = '0;
        retry_d  = retry_q;
        syn_d    = 1'b0;
        ack_d    = 1'b0;
        fin_d    = 1'b0;
        tx_seq_d = tx_seq;
        tx_ack_d = tx_ack;
        case (state_q)
            CLOSED: begin
                if (open_req) begin
                    state_d  = SYN_SENT;
                    isn_d    = isn;
                    syn_d    = 1'b1;
                    tx_seq_d = isn;
                    tx_ack_d = '0;
                    retry_d  = '0;
                end
            end
            SYN_SENT: begin
                if (rcv_syn_ack && rcv_ack == isn_p1) begin
                    state_d  = ESTABLISHED;
                    ack_d    = 1'b1;
                    tx_seq_d = isn_p1;
                    tx_ack_d = rcv_seq + SEQ_W'(1);
                    peer_d   = rcv_seq + SEQ_W'(1);
                end else if (expired) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        syn_d    = 1'b1;
                        tx_seq_d = isn_q;
                        tx_ack_d = '0;
                        retry_d  = retry_q + RW'(1);
                    end else begin
                        state_d = FAILED;
                    end
                end else if (!open_req) begin
                    state_d = CLOSED;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ESTABLISHED: begin
                if (rcv_syn_ack && rcv_ack == isn_p1) begin
                    ack_d    = 1'b1;
                    tx_seq_d = isn_p1;
                    tx_ack_d = peer_q;
                end else if (close_req) begin
`ifdef TCP_CLIENT_FSM_FIN_EN
                    state_d  = FIN_WAIT;
                    fin_d    = 1'b1;
                    tx_seq_d = isn_p1;
                    tx_ack_d = peer_q;
                    retry_d  = '0;
`else
                    state_d  = CLOSED;
`endif
                end
            end
`ifdef TCP_CLIENT_FSM_FIN_EN
            FIN_WAIT: begin
                if (rcv_fin_ack && rcv_ack == isn_p2) begin
                    state_d  = CLOSED;
                    ack_d    = 1'b1;
                    tx_seq_d = isn_p2;
                    tx_ack_d = rcv_seq + SEQ_W'(1);
                end else if (expired) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        fin_d    = 1'b1;
                        tx_seq_d = isn_p1;
                        tx_ack_d = peer_q;
                        retry_d  = retry_q + RW'(1);
                    end else begin
                        state_d = FAILED;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif
            FAILED: begin
                if (!open_req) state_d = CLOSED;
            end
            default: state_d = CLOSED;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= CLOSED;
            isn_q       <= '0;
            peer_q      <= '0;
            timer_q     <= '0;
            retry_q     <= '0;
            send_syn    <= 1'b0;
            send_ack    <= 1'b0;
            send_fin    <= 1'b0;
            tx_seq      <= '0;
            tx_ack      <= '0;
            established <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state_q     <= state_d;
            isn_q       <= isn_d;
            peer_q      <= peer_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            send_syn    <= syn_d;
            send_ack    <= ack_d;
            send_fin    <= fin_d;
            tx_seq      <= tx_seq_d;
            tx_ack      <= tx_ack_d;
            established <= (state_d == ESTABLISHED);
            fail        <= (state_d == FAILED);
        end
    end

endmodule

// File: tb/tb_tcp_client_fsm.sv
// Directed self-checking bench for tcp_client_fsm (default parameters).
// Expectations for the close path follow TCP_CLIENT_FSM_FIN_EN when it is defined.
module tb_tcp_client_fsm;

    logic        clock = 1'b0;
    logic        rst;
    logic        open_req, close_req, rcv_syn_ack, rcv_fin_ack;
    logic [31:0] isn, rcv_seq, rcv_ack;
    logic        send_syn, send_ack, send_fin, established, fail;
    logic [31:0] tx_seq, tx_ack;
    logic [2:0]  state;
    int          total = 0;
    int          bad   = 0;

    tcp_client_fsm #(.SEQ_W(32), .TIMEOUT(16), .MAX_RETRY(3)) dut (
        .clock(clock), .rst(rst), .open_req(open_req), .close_req(close_req),
        .isn(isn), .rcv_syn_ack(rcv_syn_ack), .rcv_fin_ack(rcv_fin_ack),
        .rcv_seq(rcv_seq), .rcv_ack(rcv_ack), .send_syn(send_syn),
        .send_ack(send_ack), .send_fin(send_fin), .tx_seq(tx_seq), .tx_ack(tx_ack),
        .established(established), .fail(fail), .state(state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".state"}, 32'(state), 32'd0);
        chk({tag, ".strobes"}, {29'd0, send_syn, send_ack, send_fin}, 32'd0);
        chk({tag, ".tx_seq"}, tx_seq, 32'd0);
        chk({tag, ".tx_ack"}, tx_ack, 32'd0);
        chk({tag, ".est_fail"}, {30'd0, established, fail}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; open_req = 1'b0; close_req = 1'b0; isn = 32'h0;
        rcv_syn_ack = 1'b0; rcv_fin_ack = 1'b0; rcv_seq = 32'h0; rcv_ack = 32'h0;
        #3;
        chk_all_zero("reset");
        tick(); tick();
        chk_all_zero("reset_held");
        rst = 1'b1;

        // Basic handshake: SYN, then valid SYN-ACK on the 5th edge after it
        isn = 32'h100; open_req = 1'b1;
        tick();
        chk("open.syn", 32'(send_syn), 32'd1);
        chk("open.tx_seq", tx_seq, 32'h100);
        chk("open.state", 32'(state), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("wait.syn", 32'(send_syn), 32'd0);
            chk("wait.state", 32'(state), 32'd1);
        end
        rcv_syn_ack = 1'b1; rcv_seq = 32'h500; rcv_ack = 32'h101;
        tick();
        rcv_syn_ack = 1'b0;
        chk("estab.ack", 32'(send_ack), 32'd1);
        chk("estab.tx_seq", tx_seq, 32'h101);
        chk("estab.tx_ack", tx_ack, 32'h501);
        chk("estab.est", 32'(established), 32'd1);
        chk("estab.state", 32'(state), 32'd2);
        tick();
        chk("estab.ack_pulse", 32'(send_ack), 32'd0);

        // Duplicate SYN-ACK re-sends identical ACK
        rcv_syn_ack = 1'b1;
        tick();
        rcv_syn_ack = 1'b0;
        chk("dup.ack", 32'(send_ack), 32'd1);
        chk("dup.tx_seq", tx_seq, 32'h101);
        chk("dup.tx_ack", tx_ack, 32'h501);

        open_req = 1'b0;
        tick();
        chk("openlow.state", 32'(state), 32'd2);
        chk("openlow.est", 32'(established), 32'd1);

        close_req = 1'b1;
        tick();
        close_req = 1'b0;
`ifdef TCP_CLIENT_FSM_FIN_EN
        chk("close.fin", 32'(send_fin), 32'd1);
        chk("close.tx_seq", tx_seq, 32'h101);
        chk("close.tx_ack", tx_ack, 32'h501);
        chk("close.state", 32'(state), 32'd3);
        tick();
        rcv_fin_ack = 1'b1; rcv_seq = 32'h501; rcv_ack = 32'h102;
        tick();
        rcv_fin_ack = 1'b0;
        chk("finack.ack", 32'(send_ack), 32'd1);
        chk("finack.tx_seq", tx_seq, 32'h102);
        chk("finack.tx_ack", tx_ack, 32'h502);
        chk("finack.state", 32'(state), 32'd0);
`else
        chk("close.fin", 32'(send_fin), 32'd0);
        chk("close.state", 32'(state), 32'd0);
        chk("close.est", 32'(established), 32'd0);
        tick();
        chk("close.fin_later", 32'(send_fin), 32'd0);
`endif

        // Retransmission with a bogus SYN-ACK, then exhaustion to FAILED
        isn = 32'h100; open_req = 1'b1;
        tick();
        chk("retx.syn0", 32'(send_syn), 32'd1);
        chk("retx.tx_seq0", tx_seq, 32'h100);
        isn = 32'h777;
        for (int i = 1; i <= 64; i++) begin
            if (i == 3) begin
                rcv_syn_ack = 1'b1; rcv_seq = 32'h500; rcv_ack = 32'h102;
            end else begin
                rcv_syn_ack = 1'b0;
            end
            tick();
            chk($sformatf("retx.syn@%0d", i), 32'(send_syn),
                ((i % 16 == 0) && (i < 64)) ? 32'd1 : 32'd0);
            if (i % 16 == 0 && i < 64) chk($sformatf("retx.tx_seq@%0d", i), tx_seq, 32'h100);
            if (i >= 63) chk($sformatf("retx.fail@%0d", i), 32'(fail), (i == 64) ? 32'd1 : 32'd0);
        end
        rcv_syn_ack = 1'b0;
        chk("failed.state", 32'(state), 32'd4);
        tick();
        chk("failed.hold", 32'(fail), 32'd1);
        open_req = 1'b0;
        tick();
        chk("failed.exit_state", 32'(state), 32'd0);
        chk("failed.exit_fail", 32'(fail), 32'd0);

        // Asynchronous reset mid-handshake, right after a SYN strobe
        isn = 32'h200; open_req = 1'b1;
        tick();
        chk("pre_rst.syn", 32'(send_syn), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #1 rst = 1'b1;
        isn = 32'h300;
        tick();
        chk("restart.syn", 32'(send_syn), 32'd1);
        chk("restart.tx_seq", tx_seq, 32'h300);
        chk("restart.state", 32'(state), 32'd1);
        open_req = 1'b0;
        tick();
        chk("abort.state", 32'(state), 32'd0);
        chk("abort.syn", 32'(send_syn), 32'd0);

        // Sequence wrap-around
        isn = 32'hFFFF_FFFF; open_req = 1'b1;
        tick();
        chk("wrap.syn", 32'(send_syn), 32'd1);
        chk("wrap.tx_seq0", tx_seq, 32'hFFFF_FFFF);
        rcv_syn_ack = 1'b1; rcv_seq = 32'hFFFF_FFFF; rcv_ack = 32'h0;
        tick();
        rcv_syn_ack = 1'b0;
        chk("wrap.ack", 32'(send_ack), 32'd1);
        chk("wrap.tx_seq", tx_seq, 32'h0);
        chk("wrap.tx_ack", tx_ack, 32'h0);
        chk("wrap.est", 32'(established), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
